flappy_game_engine: RTL

- Per-frame game-state engine for the Flappy VGA design.
- Produces `bird_pos`, `hole_pos` and `pipe_pos`, the object positions consumed by the pixel/colour generator, plus score and game state.
- Advances once per `frame_tick` pulse from the VGA timing block.
- Handles the flap button, gravity, pipe scrolling, pseudo-random gap placement, collision and the IDLE/PLAY/DEAD sequencing.

---
 rtl/flappy_game_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/flappy_game_engine.sv
// Per-frame game-state engine for Flappy VGA: bird physics, pipe scrolling, gap placement,
// collision and IDLE/PLAY/DEAD sequencing. All state advances on frame_tick only.
module flappy_game_engine #(
    parameter int GRAVITY    = 1,
    parameter int FLAP_VEL   = 8,
    parameter int MAX_FALL   = 8,
    parameter int PIPE_SPEED = 2,
    parameter int BIRD_START = 240,
    parameter int PIPE_START = 739,
    parameter int DEAD_HOLD  = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flap,
    output logic [8:0] bird_pos,
    output logic [8:0] hole_pos,
    output logic [9:0] pipe_pos,
    output logic [7:0] score,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic signed [5:0] GRAVITY_V    = 6'(GRAVITY);
    localparam logic signed [5:0] FLAP_V       = 6'(FLAP_VEL);
    localparam logic signed [5:0] MAX_FALL_V   = 6'(MAX_FALL);
    localparam logic [9:0]        PIPE_SPEED_V = 10'(PIPE_SPEED);
    localparam logic [8:0]        BIRD_START_V = 9'(BIRD_START);
    localparam logic [9:0]        PIPE_START_V = 10'(PIPE_START);
    localparam logic [7:0]        DEAD_HOLD_V  = 8'(DEAD_HOLD);
    localparam logic [8:0]        HOLE_RESET   = 9'd165;

    state_t             r_state;
    logic               r_sync1, r_sync2, r_sync3;
    logic               r_flap_pending;
    logic [7:0]         r_lfsr;
    logic signed [5:0]  r_vel;
    logic [7:0]         r_dead_cnt;
    logic [8:0]         r_bird;
    logic [8:0]         r_hole;
    logic [9:0]         r_pipe;
    logic [7:0]         r_score;

    logic               w_edge;
    logic               w_pend;
    logic               w_lfsr_fb;
    logic [8:0]         w_new_hole;
    logic signed [5:0]  w_vel_grav;
    logic signed [5:0]  w_vel_next;
    logic signed [5:0]  w_vel_after;
    logic signed [9:0]  w_bird_sum;
    logic               w_ceiling;
    logic               w_floor;
    logic [8:0]         w_bird_next;
    logic               w_respawn;
    logic [9:0]         w_pipe_next;
    logic [8:0]         w_hole_next;
    logic [7:0]         w_score_next;
    logic               w_overlap;
    logic               w_miss;
    logic               w_die;

    always_comb begin
        w_edge     = r_sync2 & ~r_sync3;
        // An edge arriving in the tick cycle itself still counts for that tick.
        w_pend     = r_flap_pending | w_edge;
        w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
        w_new_hole = {1'b0, r_lfsr} + 9'd40;

        w_vel_grav  = (r_vel >= MAX_FALL_V - GRAVITY_V) ? MAX_FALL_V : r_vel + GRAVITY_V;
        w_vel_next  = w_pend ? -FLAP_V : w_vel_grav;
        w_bird_sum  = $signed({1'b0, r_bird}) + $signed({{4{w_vel_next[5]}}, w_vel_next});
        w_ceiling   = w_bird_sum < 10'sd50;
        w_floor     = w_bird_sum >= 10'sd479;
        w_vel_after = w_ceiling ? 6'sd0 : w_vel_next;
        if (w_ceiling)
            w_bird_next = 9'd50;
        else if (w_floor)
            w_bird_next = 9'd479;
        else
            w_bird_next = w_bird_sum[8:0];

        w_respawn    = r_pipe <= PIPE_SPEED_V;
        w_pipe_next  = w_respawn ? PIPE_START_V : r_pipe - PIPE_SPEED_V;
        w_hole_next  = w_respawn ? w_new_hole : r_hole;
        w_score_next = (w_respawn && r_score != 8'hFF) ? r_score + 8'd1 : r_score;

        // Collision uses the post-move values, so a respawned pipe never collides.
        w_overlap = (w_pipe_next >= 10'd52) && (w_pipe_next <= 10'd198);
        w_miss    = ({1'b0, w_bird_next} < {1'b0, w_hole_next} + 10'd49) ||
                    ({1'b0, w_bird_next} > {1'b0, w_hole_next} + 10'd151);
        w_die     = w_floor | (w_overlap & w_miss);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_sync3        <= 1'b0;
            r_flap_pending <= 1'b0;
            r_lfsr         <= 8'hA5;
            r_vel          <= 6'sd0;
            r_dead_cnt     <= 8'd0;
            r_bird         <= BIRD_START_V;
            r_hole         <= HOLE_RESET;
            r_pipe         <= PIPE_START_V;
            r_score        <= 8'd0;
        end else begin
            r_sync1 <= flap;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};

            if (frame_tick)
                r_flap_pending <= 1'b0;
            else if (w_edge)
                r_flap_pending <= 1'b1;

            if (frame_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pend) begin
                            r_state <= ST_PLAY;
                            r_score <= 8'd0;
                            r_hole  <= w_new_hole;
                            r_vel   <= 6'sd0;
                        end
                    end
                    ST_PLAY: begin
                        r_vel   <= w_vel_after;
                        r_bird  <= w_bird_next;
                        r_pipe  <= w_pipe_next;
                        r_hole  <= w_hole_next;
                        r_score <= w_score_next;
                        if (w_die) begin
                            r_state    <= ST_DEAD;
                            r_dead_cnt <= 8'd0;
                        end
                    end
                    ST_DEAD: begin
                        if (w_pend && r_dead_cnt == DEAD_HOLD_V) begin
                            r_state    <= ST_IDLE;
                            r_bird     <= BIRD_START_V;
                            r_pipe     <= PIPE_START_V;
                            r_hole     <= HOLE_RESET;
                            r_vel      <= 6'sd0;
                            r_dead_cnt <= 8'd0;
                        end else if (r_dead_cnt != DEAD_HOLD_V) begin
                            r_dead_cnt <= r_dead_cnt + 8'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bird_pos   = r_bird;
    assign hole_pos   = r_hole;
    assign pipe_pos   = r_pipe;
    assign score      = r_score;
    assign game_state = r_state;
endmodule
